alu_multicycle: RTL and testbench

Parametrised, handshaked successor to the single-cycle datapath ALU. It executes the existing logical, arithmetic and compare opcodes in one cycle. It adds iterative multi-cycle operations (shift-add multiply, variable shifts) and a status-flag output. It sits between the register file and the writeback stage; the controller issues with `start` and stalls on `busy` until `done`.

---
 rtl/alu_multicycle.sv | 177 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU with single-cycle logic/arith/compare ops
// plus iterative shift-add multiply and one-bit-per-cycle logical shifts.
module alu_multicycle #(
    parameter int WORD_SIZE = 16,
    parameter int SHAMT_W   = $clog2(WORD_SIZE)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4:0]           opcode,
    input  logic [WORD_SIZE-1:0] input1,
    input  logic [WORD_SIZE-1:0] input2,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] alu_out,
    output logic [4:0]           flags
);
    localparam int W      = WORD_SIZE;
    localparam int CW_MIN = $clog2(W + 1);
    localparam int CNT_W  = (SHAMT_W > CW_MIN) ? SHAMT_W : CW_MIN;

    localparam logic [4:0] OP_NOT  = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_XOR  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_ANDI = 5'd7;
    localparam logic [4:0] OP_EQ   = 5'd8;
    localparam logic [4:0] OP_LT   = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_SHR  = 5'd12;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_SHIFT} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic [4:0]       op_q, op_next;
    logic [2*W-1:0]   acc, acc_next;
    logic [2*W-1:0]   mcand, mcand_next;
    logic [W-1:0]     mplier, mplier_next;

    logic [SHAMT_W-1:0] shamt;
    logic [2*W-1:0]     prod;
    logic [W-1:0]       shifted;
    logic               multi;
    logic               fin, carry, ovf, illegal;
    logic [W-1:0]       res;
    logic [W:0]         sum;

    // mcand doubles as the shifting operand while in S_SHIFT
    assign shamt   = input2[SHAMT_W-1:0];
    assign prod    = acc + (mplier[0] ? mcand : '0);
    assign shifted = (op_q == OP_SHL) ? (mcand[W-1:0] << 1)
                                      : (mcand[W-1:0] >> 1);
    assign multi   = (opcode == OP_MUL) ||
                     ((opcode == OP_SHL || opcode == OP_SHR) && shamt != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= '0;
            op_q    <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_out <= '0;
            flags   <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            op_q   <= op_next;
            acc    <= acc_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            busy   <= (state_next != S_IDLE);
            done   <= fin;
            if (fin) begin
                alu_out <= res;
                flags   <= {illegal, ovf, res[W-1], carry, res == '0};
            end
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        op_next     = op_q;
        acc_next    = acc;
        mcand_next  = mcand;
        mplier_next = mplier;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    op_next     = opcode;
                    acc_next    = '0;
                    mcand_next  = {{W{1'b0}}, input1};
                    mplier_next = input2;
                    if (opcode == OP_MUL) begin
                        state_next = S_MUL;
                        count_next = CNT_W'(W);
                    end else if (multi) begin
                        state_next = S_SHIFT;
                        count_next = CNT_W'(shamt);
                    end
                end
            end
            S_MUL: begin
                acc_next    = prod;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                count_next  = count - CNT_W'(1);
                if (count == CNT_W'(1)) state_next = S_IDLE;
            end
            S_SHIFT: begin
                mcand_next = {{W{1'b0}}, shifted};
                count_next = count - CNT_W'(1);
                if (count == CNT_W'(1)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        fin     = 1'b0;
        res     = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        sum     = '0;
        unique case (state)
            S_IDLE: begin
                if (start && !multi) begin
                    fin = 1'b1;
                    case (opcode)
                        OP_NOT:          res = ~input1;
                        OP_AND, OP_ANDI: res = input1 & input2;
                        OP_OR:           res = input1 | input2;
                        OP_XOR:          res = input1 ^ input2;
                        OP_ADD, OP_ADDI: begin
                            sum   = {1'b0, input1} + {1'b0, input2};
                            res   = sum[W-1:0];
                            carry = sum[W];
                            ovf   = (input1[W-1] == input2[W-1]) &&
                                    (res[W-1] != input1[W-1]);
                        end
                        OP_SUB: begin
                            res   = input1 - input2;
                            carry = input1 < input2;
                            ovf   = (input1[W-1] != input2[W-1]) &&
                                    (res[W-1] != input1[W-1]);
                        end
                        OP_EQ:  res = {{(W-1){1'b0}}, input1 == input2};
                        OP_LT:  res = {{(W-1){1'b0}}, input1 < input2};
                        // zero shift amount completes immediately
                        OP_SHL, OP_SHR: res = input1;
                        default: illegal = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                fin   = (count == CNT_W'(1));
                res   = prod[W-1:0];
                carry = |prod[2*W-1:W];
            end
            S_SHIFT: begin
                fin = (count == CNT_W'(1));
                res = shifted;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: 16- and 8-bit instances checked
// against a plain-arithmetic reference model, directed and random ops.
`timescale 1ns/1ps
module tb_alu_multicycle;
    localparam logic [4:0] OP_NOT  = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_XOR  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_ANDI = 5'd7;
    localparam logic [4:0] OP_EQ   = 5'd8;
    localparam logic [4:0] OP_LT   = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_SHR  = 5'd12;

    typedef struct {
        int         cyc;
        longint     res;
        logic [4:0] flags;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start16 = 1'b0, start8 = 1'b0;
    logic [4:0]  op16 = '0, op8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy16, done16, busy8, done8;
    logic [15:0] out16;
    logic [7:0]  out8;
    logic [4:0]  fl16, fl8;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t q16[$];
    exp_t q8[$];
    exp_t e16, e8;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    alu_multicycle #(.WORD_SIZE(16)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .opcode(op16),
        .input1(a16), .input2(b16), .busy(busy16), .done(done16),
        .alu_out(out16), .flags(fl16)
    );

    alu_multicycle #(.WORD_SIZE(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .opcode(op8),
        .input1(a8), .input2(b8), .busy(busy8), .done(done8),
        .alu_out(out8), .flags(fl8)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Edge offset after the accepting edge E at which done is raised:
    // 0 for single-cycle ops, w for multiply, n for a shift by n>0.
    function automatic exp_t model(int w, logic [4:0] op,
                                   longint a, longint b, int now);
        exp_t   e;
        longint m, half, sa, sb, r, s;
        bit     c, v, il;
        int     off, n;
        m    = longint'(1) << w;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        r = 0; s = 0; c = 0; v = 0; il = 0; off = 0;
        n = int'(b % w);
        case (op)
            OP_NOT:          r = m - 1 - a;
            OP_AND, OP_ANDI: r = a & b;
            OP_OR:           r = a | b;
            OP_XOR:          r = a ^ b;
            OP_ADD, OP_ADDI: begin r = a + b; c = (r >= m); s = sa + sb; end
            OP_SUB:          begin r = a - b; c = (a < b); s = sa - sb; end
            OP_EQ:           r = (a == b) ? 1 : 0;
            OP_LT:           r = (a < b) ? 1 : 0;
            OP_MUL:          begin r = a * b; c = (r >= m); off = w; end
            OP_SHL:          begin r = a << n; off = n; end
            OP_SHR:          begin r = a >> n; off = n; end
            default:         il = 1;
        endcase
        if (op == OP_ADD || op == OP_ADDI || op == OP_SUB)
            v = (s >= half) || (s < -half);
        r = ((r % m) + m) % m;
        e.cyc   = now + 1 + off;
        e.res   = r;
        e.flags = {il, v, (r >= half), c, (r == 0)};
        return e;
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic issue(int w, logic [4:0] op, longint a, longint b, bit push);
        longint mask, am, bm;
        mask = (longint'(1) << w) - 1;
        am = a & mask;
        bm = b & mask;
        if (w == 16) begin
            start16 = 1'b1; op16 = op; a16 = am[15:0]; b16 = bm[15:0];
            if (push) q16.push_back(model(16, op, am, bm, cyc));
        end else begin
            start8 = 1'b1; op8 = op; a8 = am[7:0]; b8 = bm[7:0];
            if (push) q8.push_back(model(8, op, am, bm, cyc));
        end
        step(1);
    endtask

    task automatic finish_wait(int w);
        int n;
        n = 0;
        if (w == 16) start16 = 1'b0;
        else start8 = 1'b0;
        while (((w == 16) ? q16.size() : q8.size()) != 0 && n < 100) begin
            step(1);
            n++;
        end
        if (((w == 16) ? q16.size() : q8.size()) != 0) begin
            checks++;
            fails++;
            $display("FAIL timeout: w=%0d pending results never completed", w);
            q16.delete();
            q8.delete();
        end
    endtask

    always @(negedge clock) begin
        if (done16) begin
            if (q16.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL done16 unexpected at cycle %0d", cyc);
            end else begin
                e16 = q16.pop_front();
                check("res16", out16, e16.res);
                check("flags16", fl16, e16.flags);
                check("cycle16", cyc, e16.cyc);
                check("busy16_at_done", busy16, 0);
            end
        end
        if (done8) begin
            if (q8.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL done8 unexpected at cycle %0d", cyc);
            end else begin
                e8 = q8.pop_front();
                check("res8", out8, e8.res);
                check("flags8", fl8, e8.flags);
                check("cycle8", cyc, e8.cyc);
                check("busy8_at_done", busy8, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int         w, sel, n;
        logic [4:0] op;
        longint     a, b;

        reset = 1'b1;
        step(3);
        check("rst_busy16", busy16, 0);
        check("rst_done16", done16, 0);
        check("rst_out16", out16, 0);
        check("rst_flags16", fl16, 0);
        check("rst_busy8", busy8, 0);
        check("rst_out8", out8, 0);
        check("rst_flags8", fl8, 0);
        reset = 1'b0;

        issue(16, OP_ADD, 'h7FFF, 'h0001, 1);
        issue(16, OP_SUB, 'h1234, 'h5678, 1);
        finish_wait(16);
        check("sub_out", out16, 'hBBBC);
        check("sub_flags", fl16, 5'b00110);

        issue(16, OP_MUL, 'h0123, 'h0010, 1);
        check("mul_busy", busy16, 1);
        finish_wait(16);
        check("mul1_out", out16, 'h1230);
        issue(16, OP_MUL, 'h1234, 'h0100, 1);
        finish_wait(16);
        check("mul2_out", out16, 'h3400);
        check("mul2_carry", fl16[1], 1);

        issue(16, OP_SHL, 'h0001, 15, 1);
        finish_wait(16);
        check("shl15_out", out16, 'h8000);
        issue(16, OP_SHR, 'h8000, 0, 1);
        finish_wait(16);
        issue(16, OP_SHR, 'h00F0, 4, 1);
        finish_wait(16);
        check("shr4_out", out16, 'h000F);

        issue(16, OP_EQ, 'h1234, 'h1234, 1);
        issue(16, OP_LT, 'h5678, 'h1234, 1);
        issue(16, 5'd20, 'h1111, 'h2222, 1);
        finish_wait(16);
        check("illegal_flags", fl16, 5'b10001);

        // start while busy is ignored, operands changing after acceptance
        issue(16, OP_MUL, 'h0123, 'h0010, 1);
        start16 = 1'b0;
        step(2);
        issue(16, OP_ADD, 'hFFFF, 'hFFFF, 0);
        start16 = 1'b0;
        a16 = 16'hDEAD;
        b16 = 16'hBEEF;
        finish_wait(16);
        check("mul_ignored_start", out16, 'h1230);

        // reset mid-multiply drops the op without a done pulse
        issue(16, OP_MUL, 'h1234, 'h0100, 0);
        start16 = 1'b0;
        step(2);
        issue(16, OP_ADD, 'h0001, 'h0001, 0);
        start16 = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("abort_busy", busy16, 0);
        check("abort_done", done16, 0);
        check("abort_out", out16, 0);
        check("abort_flags", fl16, 0);
        issue(16, OP_ADD, 'h0002, 'h0003, 1);
        finish_wait(16);
        check("post_abort_add", out16, 'h0005);

        issue(8, OP_ADD, 'hFF, 'h01, 1);
        finish_wait(8);
        check("w8_add_out", out8, 'h00);
        check("w8_add_flags", fl8, 5'b00011);
        issue(8, OP_MUL, 'h0F, 'h11, 1);
        finish_wait(8);
        check("w8_mul_out", out8, 'hFF);

        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 16 : 8;
            for (int i = 0; i < 80; i++) begin
                sel = $urandom_range(0, 15);
                op  = (sel < 13) ? 5'(sel) : 5'($urandom_range(13, 31));
                a   = longint'($urandom);
                b   = longint'($urandom);
                n   = int'((b & ((longint'(1) << w) - 1)) % w);
                issue(w, op, a, b, 1);
                if (!(op == OP_MUL || ((op == OP_SHL || op == OP_SHR) && n != 0))
                    && $urandom_range(0, 1) == 1)
                    continue;
                finish_wait(w);
            end
            finish_wait(w);
        end

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
